// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst read path.
package ram_pkg;

  // Default geometry when the reader is instantiated without overrides.
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Output buffer depth: one word being presented plus one arriving from the RAM.
  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN
  } rd_state_e;

  // A new read may issue only if every word already owed to the buffer, plus
  // this one, still fits once the current pop (if any) has drained a slot.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    logic [OCC_W:0] w_owed;
    w_owed = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);
    return w_owed < (OCC_W+1)'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Command, RAM port B and output stream signals of the burst reader.
interface ram_burst_reader_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = ADDR_W + 1
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  // Reader side.
  modport master (
    input  start, base_addr, len, doutb, m_ready,
    output busy, done, enb, addrb, m_valid, m_data, m_last
  );

  // Environment side: command source, RAM and stream consumer.
  modport slave (
    output start, base_addr, len, doutb, m_ready,
    input  busy, done, enb, addrb, m_valid, m_data, m_last
  );

endinterface

// File: rtl/ram_burst_reader_fifo.sv
// Two-entry show-ahead buffer holding {last, data} words returned by the RAM.
module ram_rd_skid_fifo
  import ram_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic             o_valid,
  output logic [OCC_W-1:0] o_occ
);

  logic [W-1:0]     r_mem [FIFO_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_push;
  logic             w_pop;

  // A push into a full buffer is accepted only when a pop frees the slot that
  // same cycle; the head word is read out before the write lands.
  assign w_pop  = i_pop && (r_occ != '0);
  assign w_push = i_push && ((r_occ < OCC_W'(FIFO_DEPTH)) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/ram_burst_reader.sv
// Turns one start command into a burst of RAM port B reads and streams the
// returned words out with valid/ready backpressure.
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  ram_burst_reader_if.master  bus
);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;

  logic              w_issue;
  logic              w_done_nxt;
  logic              w_accept;
  logic              w_pop;
  logic              w_last_issue;
  logic              w_fifo_valid;
  logic [DATA_W:0]   w_fifo_rdata;
  logic [OCC_W-1:0]  w_occ;

  assign w_accept     = (r_state == RD_IDLE) && bus.start && (bus.len != '0);
  assign w_pop        = w_fifo_valid && bus.m_ready;
  assign w_last_issue = ((r_issued + LEN_W'(1)) == r_len);

  // Next state, read issue and completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) w_state_nxt = RD_READ;
          else               w_done_nxt  = 1'b1;
        end
      end
      RD_READ: begin
        if (credit_ok(w_occ, r_inflight, w_pop)) begin
          w_issue = 1'b1;
          if (w_last_issue) w_state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (w_pop && w_fifo_rdata[DATA_W]) begin
          w_state_nxt = RD_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Burst counters, read-latency tracking and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr          <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= w_done_nxt;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_issue;
      if (w_accept) begin
        r_addr   <= bus.base_addr;
        r_len    <= bus.len;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_issued <= r_issued + LEN_W'(1);
      end
    end
  end

  // doutb is only trusted in the cycle right after an issue.
  ram_rd_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_wdata ({r_inflight_last, bus.doutb}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_occ   (w_occ)
  );

  assign bus.busy    = (r_state != RD_IDLE);
  assign bus.done    = r_done;
  assign bus.enb     = w_issue;
  assign bus.addrb   = r_addr;
  assign bus.m_valid = w_fifo_valid;
  assign bus.m_data  = w_fifo_rdata[DATA_W-1:0];
  assign bus.m_last  = w_fifo_rdata[DATA_W];

endmodule
